ipsxe_floating_point_fx2fl_axi_v2_0: RTL and testbench
======================================================

// Module: ipsxe_floating_point_fx2fl_axi_v2_0
// PURPOSE
//  Second-generation fixed-to-float converter. Accepts signed/unsigned fixed-point operands up to 64 bits on an
//  AXI4-Stream slave and produces IEEE-754-style floats on an AXI4-Stream master. Adds four things over v1:
//  full tready backpressure, runtime rounding mode, overflow/inexact flags and tuser passthrough.
//  Sits in the floating-point IP library beside the other ipsxe_floating_point_* operators.
// PARAMETERS
//  FIXED_INT_BIT   32  integer bits, including the sign bit when INT_TYPE=0
//  FIXED_FRAC_BIT  0   fraction bits of the fixed-point input
//  FLOAT_EXP_BIT   8   exponent width of the result
//  FLOAT_FRAC_BIT  24  significand width, including the hidden one
//  INT_TYPE        0   0 = two's-complement signed input; 1 = unsigned input
//  USER_WIDTH      1   width of the tuser sideband
// PORTS
//  i_aclk                  in   1                          clock
//  i_areset_n              in   1                          asynchronous active-low reset
//  i_aclken                in   1                          global clock enable; 0 freezes all state
//  i_axi4s_a_tdata         in   FIXED_INT_BIT+FIXED_FRAC_BIT  fixed-point operand
//  i_axi4s_a_tuser         in   USER_WIDTH                 sideband, carried unchanged to the output
//  i_axi4s_a_tvalid        in   1                          operand valid
//  o_axi4s_a_tready        out  1                          operand accepted when tvalid & tready
//  i_rnd_mode              in   2                          sampled with the operand: 0 RNE, 1 RTZ, 2 RUP(+inf), 3 RDN(-inf)
//  o_axi4s_result_tdata    out  FLOAT_EXP_BIT+FLOAT_FRAC_BIT  {sign, exp, frac without hidden bit}
//  o_axi4s_result_tuser    out  USER_WIDTH                 sideband of this result
//  o_axi4s_result_tflags   out  2                          {overflow, inexact}
//  o_axi4s_result_tvalid   out  1                          result valid
//  i_axi4s_result_tready   in   1                          downstream ready
// BEHAVIOUR
//  - Clock and reset: one clock, i_aclk. i_areset_n is asynchronous and active-low.
//    Reset clears every register and every stage-valid bit. All outputs reset to 0.
//    Reset mid-operation discards in-flight data; no partial result is ever emitted.
//  - Pipeline: 5 stages.
//    S1 capture: sign, |x|, rnd_mode, tuser.
//    S2 leading-one detect: zero flag and one-location.
//    S3 normalise shift.
//    S4 round plus exponent and flag computation.
//    S5 output register.
//    Latency is exactly 5 enabled cycles from acceptance to tvalid when the pipeline is not stalled.
//  - Flow control: adv = i_aclken & (~o_axi4s_result_tvalid | i_axi4s_result_tready).
//    All stages move together only when adv=1; otherwise every stage holds, including bubbles.
//    o_axi4s_a_tready = adv. This is a combinational path from i_axi4s_result_tready and i_aclken.
//  - Stage valid bits: each stage carries one. Bubbles propagate with valid=0 and never assert o_*_tvalid.
//    Throughput is 1 result/cycle under continuous ready.
//  - Output stability: while tvalid=1 and tready=0, tdata, tuser and tflags hold stable (AXI rule).
//  - Magnitude: negative signed inputs are two's-complemented into an N-bit unsigned magnitude,
//    where N = FIXED_INT_BIT+FIXED_FRAC_BIT. The most-negative value yields magnitude 2^(N-1) with no wrap.
//  - Exponent: the internal exponent is computed in FLOAT_EXP_BIT+2 signed bits.
//    biased = loc + BIAS - FIXED_FRAC_BIT, plus 1 if rounding carries out of the significand.
//  - Rounding: applies to the N-FLOAT_FRAC_BIT bits below the significand, using guard/round/sticky.
//    RNE: ties go to even.
//    RUP: increments if inexact and positive. RDN: increments if inexact and negative.
//    When N <= FLOAT_FRAC_BIT the conversion is exact: no rounding logic, inexact=0.
//  - Zero input: result is +0 (sign forced to 0), flags 00.
//  - Overflow: raised when biased >= 2^FLOAT_EXP_BIT-1. The result then depends on the mode:
//    RNE gives ±inf.
//    RTZ gives ±max-finite.
//    RUP gives +inf for a positive result and -max-finite for a negative one.
//    RDN gives +max-finite for a positive result and -inf for a negative one.
//    In every case overflow=1 and inexact=1.
//  - Elaboration check: an $error fires if (2^(FLOAT_EXP_BIT-1)-1) - FIXED_FRAC_BIT < 1.
//    This excludes denormal results. If N > 64, an $error fires as well.
// STRUCTURE
//  - Defines file ipsxe_floating_point_fx2fl_defines_v2_0.vh holds:
//    the RND_RNE, RND_RTZ, RND_RUP and RND_RDN encodings;
//    the flag bit indices;
//    the width helper localparams INT_WIDTH (32 or 64) and SHIFT_WIDTH.
//  - Sub-module ipsxe_floating_point_lzc_v2_0 #(WIDTH, LOC_BITS): registered leading-one locator.
//    It has a hold input driven by adv and outputs {zero, loc}. It forms stage S2.
//  - The rest is a top-level datapath with explicit per-stage registers gated by adv.
// TESTING  (defaults, single precision, RNE unless stated)
//  1. Basic integers: 0x00000001 -> 0x3F800000; 0xFFFFFFFF -> 0xBF800000. Flags 00, 5 cycles after acceptance.
//  2. Most-negative and zero: 0x80000000 -> 0xCF000000, flags 00; 0x00000000 -> 0x00000000, flags 00.
//  3. Rounding, input 0x01000001:
//     RNE -> 0x4B800000, inexact=1.
//     RUP -> 0x4B800001.
//     Negated input under RDN -> 0xCB800001.
//  4. Fraction and unsigned:
//     FIXED_FRAC_BIT=8, input 0x00000180 -> 0x3FC00000.
//     INT_TYPE=1, input 0xFFFFFFFF -> 0x4F800000, inexact=1.
//  5. Overflow, half precision (EXP=5, FRAC=11), input 70000:
//     RNE -> 0x7C00, flags 11.
//     RTZ -> 0x7BFF, flags 11.
//  6. Backpressure: stream 20 random operands with random tready and i_aclken toggling.
//     Required: outputs match the reference model in order, none lost or duplicated.
//     Required: tdata, tuser and tflags stay stable while stalled.
//     Assert reset mid-stream: tvalid=0 on the next cycle.

Source files
------------

// File: rtl/ipsxe_floating_point_fx2fl_v2_0_pkg.sv
// ipsxe_floating_point_fx2fl_v2_0_pkg
//   Shared encodings and helpers for the v2 fixed-to-float converter:
//   rounding-mode enum, result flag bit positions and a width helper.
package ipsxe_floating_point_fx2fl_v2_0_pkg;

  // Rounding-mode encoding as presented on i_rnd_mode
  typedef enum logic [1:0] {
    RND_RNE = 2'd0,   // round to nearest, ties to even
    RND_RTZ = 2'd1,   // round toward zero
    RND_RUP = 2'd2,   // round toward +inf
    RND_RDN = 2'd3    // round toward -inf
  } rnd_mode_e;

  // Bit positions inside o_axi4s_result_tflags
  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_WIDTH    = 2;

  // Bits needed to hold a bit index 0..n-1 (at least one bit)
  function automatic int unsigned loc_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_lzc_v2_0.sv
// ipsxe_floating_point_lzc_v2_0
//   Registered leading-one locator (pipeline stage S2).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   adv_i         : 1 = register loads, 0 = register holds
//   data_i        : unsigned magnitude to scan
//   zero_o        : registered, 1 when data_i was all zeros
//   loc_o         : registered index of the most significant set bit
module ipsxe_floating_point_lzc_v2_0 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LOC_BITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                adv_i,
  input  logic [WIDTH-1:0]    data_i,
  output logic                zero_o,
  output logic [LOC_BITS-1:0] loc_o
);

  logic                zero_d, zero_q;
  logic [LOC_BITS-1:0] loc_d,  loc_q;

  // Priority scan: later (higher) set bits overwrite earlier ones
  always_comb begin
    zero_d = 1'b1;
    loc_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (data_i[i]) begin
        zero_d = 1'b0;
        loc_d  = LOC_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q <= 1'b0;
      loc_q  <= '0;
    end else if (adv_i) begin
      zero_q <= zero_d;
      loc_q  <= loc_d;
    end
  end

  assign zero_o = zero_q;
  assign loc_o  = loc_q;

endmodule

// File: rtl/ipsxe_floating_point_fx2fl_axi_v2_0.sv
// ipsxe_floating_point_fx2fl_axi_v2_0
//   Five-stage fixed-point to floating-point converter with AXI4-Stream ports.
//   S1 capture sign/|x|, S2 leading-one locate, S3 normalise, S4 round/exponent/flags,
//   S5 output register. All stages advance together on adv; otherwise everything holds.
//   i_aclk / i_areset_n / i_aclken : clock, async active-low reset, global enable
//   i_axi4s_a_*                    : operand stream (tdata, tuser, tvalid, tready)
//   i_rnd_mode                     : rounding mode, sampled with the operand
//   o_axi4s_result_*               : result stream (tdata, tuser, tflags, tvalid, tready)
module ipsxe_floating_point_fx2fl_axi_v2_0
  import ipsxe_floating_point_fx2fl_v2_0_pkg::*;
#(
  parameter int unsigned FIXED_INT_BIT  = 32,
  parameter int unsigned FIXED_FRAC_BIT = 0,
  parameter int unsigned FLOAT_EXP_BIT  = 8,
  parameter int unsigned FLOAT_FRAC_BIT = 24,
  parameter int unsigned INT_TYPE       = 0,
  parameter int unsigned USER_WIDTH     = 1
) (
  input  logic                                    i_aclk,
  input  logic                                    i_areset_n,
  input  logic                                    i_aclken,
  input  logic [FIXED_INT_BIT+FIXED_FRAC_BIT-1:0] i_axi4s_a_tdata,
  input  logic [USER_WIDTH-1:0]                   i_axi4s_a_tuser,
  input  logic                                    i_axi4s_a_tvalid,
  output logic                                    o_axi4s_a_tready,
  input  logic [1:0]                              i_rnd_mode,
  output logic [FLOAT_EXP_BIT+FLOAT_FRAC_BIT-1:0] o_axi4s_result_tdata,
  output logic [USER_WIDTH-1:0]                   o_axi4s_result_tuser,
  output logic [1:0]                              o_axi4s_result_tflags,
  output logic                                    o_axi4s_result_tvalid,
  input  logic                                    i_axi4s_result_tready
);

  localparam int unsigned N           = FIXED_INT_BIT + FIXED_FRAC_BIT;
  localparam int unsigned E           = FLOAT_EXP_BIT;
  localparam int unsigned F           = FLOAT_FRAC_BIT;
  localparam int unsigned RW          = E + F;
  localparam int unsigned SW          = F + 1;
  localparam int unsigned EW          = E + 2;
  localparam int unsigned SHIFT_WIDTH = loc_bits(N);
  localparam int unsigned BIAS        = (2 ** (E - 1)) - 1;
  localparam int unsigned EXP_MAX     = (2 ** E) - 1;
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);

  // Configurations that would need denormal results or exceed 64-bit input
  if (int'(BIAS) - int'(FIXED_FRAC_BIT) < 1) begin : g_chk_denorm
    $error("fx2fl: FIXED_FRAC_BIT too large for FLOAT_EXP_BIT (denormal results)");
  end
  if (N > 64) begin : g_chk_width
    $error("fx2fl: FIXED_INT_BIT+FIXED_FRAC_BIT must not exceed 64");
  end

  // Global advance: shared by every stage and presented as the input ready
  logic adv_c;
  logic res_vld_q;
  assign adv_c            = i_aclken & (~res_vld_q | i_axi4s_result_tready);
  assign o_axi4s_a_tready = adv_c;

  // ---------------- S1: sign and magnitude capture ----------------
  logic                  in_neg_c;
  logic [N-1:0]          mag_c;
  logic                  s1_vld_q, s1_sign_q;
  logic [N-1:0]          s1_mag_q;
  rnd_mode_e             s1_rnd_q;
  logic [USER_WIDTH-1:0] s1_user_q;

  // Two's complement in N bits maps the most-negative value to 2^(N-1) exactly
  assign in_neg_c = (INT_TYPE == 0) && i_axi4s_a_tdata[N-1];
  assign mag_c    = in_neg_c ? N'(~i_axi4s_a_tdata + 1'b1) : i_axi4s_a_tdata;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_rnd_q  <= RND_RNE;
      s1_user_q <= '0;
    end else if (adv_c) begin
      s1_vld_q  <= i_axi4s_a_tvalid;
      s1_sign_q <= in_neg_c;
      s1_mag_q  <= mag_c;
      s1_rnd_q  <= rnd_mode_e'(i_rnd_mode);
      s1_user_q <= i_axi4s_a_tuser;
    end
  end

  // ---------------- S2: leading-one detect ----------------
  logic                   s2_zero;
  logic [SHIFT_WIDTH-1:0] s2_loc;
  logic                   s2_vld_q, s2_sign_q;
  logic [N-1:0]           s2_mag_q;
  rnd_mode_e              s2_rnd_q;
  logic [USER_WIDTH-1:0]  s2_user_q;

  ipsxe_floating_point_lzc_v2_0 #(
    .WIDTH    (N),
    .LOC_BITS (SHIFT_WIDTH)
  ) u_lzc (
    .clk_i  (i_aclk),
    .rst_ni (i_areset_n),
    .adv_i  (adv_c),
    .data_i (s1_mag_q),
    .zero_o (s2_zero),
    .loc_o  (s2_loc)
  );

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_mag_q  <= '0;
      s2_rnd_q  <= RND_RNE;
      s2_user_q <= '0;
    end else if (adv_c) begin
      s2_vld_q  <= s1_vld_q;
      s2_sign_q <= s1_sign_q;
      s2_mag_q  <= s1_mag_q;
      s2_rnd_q  <= s1_rnd_q;
      s2_user_q <= s1_user_q;
    end
  end

  // ---------------- S3: normalise leading one to bit N-1 ----------------
  logic [SHIFT_WIDTH-1:0] shamt_c;
  logic                   s3_vld_q, s3_sign_q, s3_zero_q;
  logic [SHIFT_WIDTH-1:0] s3_loc_q;
  logic [N-1:0]           s3_norm_q;
  rnd_mode_e              s3_rnd_q;
  logic [USER_WIDTH-1:0]  s3_user_q;

  assign shamt_c = SHIFT_WIDTH'(N - 1) - s2_loc;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s3_vld_q  <= 1'b0;
      s3_sign_q <= 1'b0;
      s3_zero_q <= 1'b0;
      s3_loc_q  <= '0;
      s3_norm_q <= '0;
      s3_rnd_q  <= RND_RNE;
      s3_user_q <= '0;
    end else if (adv_c) begin
      s3_vld_q  <= s2_vld_q;
      s3_sign_q <= s2_sign_q;
      s3_zero_q <= s2_zero;
      s3_loc_q  <= s2_loc;
      s3_norm_q <= s2_mag_q << shamt_c;
      s3_rnd_q  <= s2_rnd_q;
      s3_user_q <= s2_user_q;
    end
  end

  // ---------------- S4: round, exponent, flags ----------------
  logic [F-1:0]           sig_c;
  logic                   inc_c, inexact_c;

  if (N <= F) begin : g_exact
    // Whole magnitude fits in the significand: conversion is exact
    assign sig_c     = F'(s3_norm_q) << (F - N);
    assign inc_c     = 1'b0;
    assign inexact_c = 1'b0;
  end else begin : g_round
    localparam int unsigned R = N - F;
    logic [R-1:0] rest_c;
    logic         guard_c, sticky_c;

    always_comb begin
      sig_c     = s3_norm_q[N-1:R];
      rest_c    = s3_norm_q[R-1:0];
      guard_c   = rest_c[R-1];
      sticky_c  = |R'(rest_c << 1);
      inexact_c = |rest_c;
      inc_c     = 1'b0;
      case (s3_rnd_q)
        RND_RNE: inc_c = guard_c & (sticky_c | sig_c[0]);
        RND_RTZ: inc_c = 1'b0;
        RND_RUP: inc_c = inexact_c & ~s3_sign_q;
        RND_RDN: inc_c = inexact_c &  s3_sign_q;
        default: inc_c = 1'b0;
      endcase
    end
  end

  logic [SW-1:0]         sig_r_c;
  logic                  carry_c, sign_c, ovf_c, to_inf_c;
  logic [F-2:0]          frac_c;
  logic signed [EW-1:0]  biased_c;
  logic [RW-1:0]         s4_res_d;
  logic [FLAG_WIDTH-1:0] s4_flags_d;
  logic                  s4_vld_q;
  logic [RW-1:0]         s4_res_q;
  logic [FLAG_WIDTH-1:0] s4_flags_q;
  logic [USER_WIDTH-1:0] s4_user_q;

  always_comb begin
    sig_r_c  = {1'b0, sig_c} + SW'(inc_c);
    carry_c  = sig_r_c[F];
    // On carry-out the significand is 1.000..0, so the shifted field is all zeros
    frac_c   = carry_c ? sig_r_c[F-1:1] : sig_r_c[F-2:0];
    biased_c = EW'(s3_loc_q) + EW'(BIAS) - EW'(FIXED_FRAC_BIT) + EW'(carry_c);
    sign_c   = s3_sign_q & ~s3_zero_q;
    ovf_c    = biased_c >= EXP_MAX_S;
    to_inf_c = (s3_rnd_q == RND_RNE) |
               ((s3_rnd_q == RND_RUP) & ~sign_c) |
               ((s3_rnd_q == RND_RDN) &  sign_c);

    s4_res_d   = {sign_c, biased_c[E-1:0], frac_c};
    s4_flags_d = '0;
    if (s3_zero_q) begin
      s4_res_d = '0;
    end else if (ovf_c) begin
      s4_res_d = to_inf_c ? {sign_c, {E{1'b1}}, {(F-1){1'b0}}}
                          : {sign_c, {(E-1){1'b1}}, 1'b0, {(F-1){1'b1}}};
      s4_flags_d[FLAG_OVERFLOW] = 1'b1;
      s4_flags_d[FLAG_INEXACT]  = 1'b1;
    end else begin
      s4_flags_d[FLAG_INEXACT]  = inexact_c;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s4_vld_q   <= 1'b0;
      s4_res_q   <= '0;
      s4_flags_q <= '0;
      s4_user_q  <= '0;
    end else if (adv_c) begin
      s4_vld_q   <= s3_vld_q;
      s4_res_q   <= s4_res_d;
      s4_flags_q <= s4_flags_d;
      s4_user_q  <= s3_user_q;
    end
  end

  // ---------------- S5: output register ----------------
  logic [RW-1:0]         res_data_q;
  logic [FLAG_WIDTH-1:0] res_flags_q;
  logic [USER_WIDTH-1:0] res_user_q;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      res_vld_q   <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_user_q  <= '0;
    end else if (adv_c) begin
      res_vld_q   <= s4_vld_q;
      res_data_q  <= s4_res_q;
      res_flags_q <= s4_flags_q;
      res_user_q  <= s4_user_q;
    end
  end

  assign o_axi4s_result_tvalid = res_vld_q;
  assign o_axi4s_result_tdata  = res_data_q;
  assign o_axi4s_result_tflags = res_flags_q;
  assign o_axi4s_result_tuser  = res_user_q;

endmodule

// File: tb/tb_ipsxe_floating_point_fx2fl_axi_v2_0.sv
// Testbench: four converter configurations share one operand stream;
// directed vectors with hand-computed results, then a randomised
// backpressure stream on the default configuration, then mid-stream reset.
module tb_ipsxe_floating_point_fx2fl_axi_v2_0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] tdata;
  logic        tuser;
  logic        tvalid;
  logic [1:0]  rnd;
  logic        rdy;

  logic        a_rdy_a, a_rdy_b, a_rdy_c, a_rdy_d;
  logic [31:0] res_a, res_b, res_c;
  logic [15:0] res_d;
  logic        user_a, user_b, user_c, user_d;
  logic [1:0]  flags_a, flags_b, flags_c, flags_d;
  logic        ov_a, ov_b, ov_c, ov_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A: signed 32.0 -> single
  ipsxe_floating_point_fx2fl_axi_v2_0 u_dut_a (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en),
    .i_axi4s_a_tdata(tdata), .i_axi4s_a_tuser(tuser), .i_axi4s_a_tvalid(tvalid),
    .o_axi4s_a_tready(a_rdy_a), .i_rnd_mode(rnd),
    .o_axi4s_result_tdata(res_a), .o_axi4s_result_tuser(user_a),
    .o_axi4s_result_tflags(flags_a), .o_axi4s_result_tvalid(ov_a),
    .i_axi4s_result_tready(rdy));

  // B: signed 24.8 -> single
  ipsxe_floating_point_fx2fl_axi_v2_0 #(.FIXED_INT_BIT(24), .FIXED_FRAC_BIT(8)) u_dut_b (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en),
    .i_axi4s_a_tdata(tdata), .i_axi4s_a_tuser(tuser), .i_axi4s_a_tvalid(tvalid),
    .o_axi4s_a_tready(a_rdy_b), .i_rnd_mode(rnd),
    .o_axi4s_result_tdata(res_b), .o_axi4s_result_tuser(user_b),
    .o_axi4s_result_tflags(flags_b), .o_axi4s_result_tvalid(ov_b),
    .i_axi4s_result_tready(rdy));

  // C: unsigned 32.0 -> single
  ipsxe_floating_point_fx2fl_axi_v2_0 #(.INT_TYPE(1)) u_dut_c (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en),
    .i_axi4s_a_tdata(tdata), .i_axi4s_a_tuser(tuser), .i_axi4s_a_tvalid(tvalid),
    .o_axi4s_a_tready(a_rdy_c), .i_rnd_mode(rnd),
    .o_axi4s_result_tdata(res_c), .o_axi4s_result_tuser(user_c),
    .o_axi4s_result_tflags(flags_c), .o_axi4s_result_tvalid(ov_c),
    .i_axi4s_result_tready(rdy));

  // D: signed 32.0 -> half
  ipsxe_floating_point_fx2fl_axi_v2_0 #(.FLOAT_EXP_BIT(5), .FLOAT_FRAC_BIT(11)) u_dut_d (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en),
    .i_axi4s_a_tdata(tdata), .i_axi4s_a_tuser(tuser), .i_axi4s_a_tvalid(tvalid),
    .o_axi4s_a_tready(a_rdy_d), .i_rnd_mode(rnd),
    .o_axi4s_result_tdata(res_d), .o_axi4s_result_tuser(user_d),
    .o_axi4s_result_tflags(flags_d), .o_axi4s_result_tvalid(ov_d),
    .i_axi4s_result_tready(rdy));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference for configuration A: integer divide/remainder rounding
  function automatic logic [31:0] ref_a(input logic [31:0] x, input logic [1:0] m,
                                        output logic ix);
    logic        neg, up;
    logic [63:0] mag, q, r, half;
    int          msb, sh, e;
    neg = x[31];
    mag = neg ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    ix  = 1'b0;
    if (mag == 64'd0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) msb = i;
    if (msb <= 23) begin
      q = mag << (23 - msb); r = 64'd0; half = 64'd1;
    end else begin
      sh = msb - 23; q = mag >> sh; r = mag - (q << sh); half = 64'd1 << (sh - 1);
    end
    ix = (r != 64'd0);
    case (m)
      2'd0:    up = (r > half) || ((r == half) && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = ix && !neg;
      default: up = ix && neg;
    endcase
    q = q + {63'd0, up};
    e = msb + 127;
    if (q[24]) begin q = q >> 1; e++; end
    return {neg, 8'(e), q[22:0]};
  endfunction

  // Drive one operand with ready held high; return cycles until A's result is valid
  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic u, output int lat);
    @(negedge clk);
    tdata = d; rnd = m; tuser = u; tvalid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    tvalid = 1'b0;
    #1;
    while (!ov_a && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
  endtask

  logic [34:0] exp_q[$];
  logic [34:0] obs, prev_obs;
  logic [31:0] exp_d;
  logic        ix, acc, prev_stall;
  int          lat, sent, got, cyc, cnt;

  initial begin
    rst_n = 1'b0; en = 1'b1; rdy = 1'b1; tvalid = 1'b0;
    tdata = '0; tuser = 1'b0; rnd = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tvalid", ov_a, 0);
    check_eq("rst_tdata", res_a, 0);
    check_eq("rst_tflags", flags_a, 0);
    check_eq("rst_tready", a_rdy_a, 1);
    en = 1'b0; #1;
    check_eq("tready_aclken0", a_rdy_a, 0);
    en = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    // Basic integers, latency and tuser
    send(32'h0000_0001, 2'd0, 1'b1, lat);
    check_eq("one_lat", lat, 5);
    check_eq("one_a", res_a, 32'h3F80_0000);
    check_eq("one_flags", flags_a, 2'b00);
    check_eq("one_user", user_a, 1'b1);
    send(32'hFFFF_FFFF, 2'd0, 1'b0, lat);
    check_eq("m1_lat", lat, 5);
    check_eq("m1_a", res_a, 32'hBF80_0000);
    check_eq("m1_user", user_a, 1'b0);
    check_eq("u_max_c", res_c, 32'h4F80_0000);
    check_eq("u_max_c_flags", flags_c, 2'b01);
    // Most-negative and zero
    send(32'h8000_0000, 2'd0, 1'b0, lat);
    check_eq("minneg_a", res_a, 32'hCF00_0000);
    check_eq("minneg_flags", flags_a, 2'b00);
    send(32'h0000_0000, 2'd3, 1'b0, lat);
    check_eq("zero_a", res_a, 32'h0);
    check_eq("zero_flags", flags_a, 2'b00);
    // Rounding at the 24-bit boundary
    send(32'h0100_0001, 2'd0, 1'b0, lat);
    check_eq("rne_a", res_a, 32'h4B80_0000);
    check_eq("rne_flags", flags_a, 2'b01);
    send(32'h0100_0001, 2'd2, 1'b0, lat);
    check_eq("rup_a", res_a, 32'h4B80_0001);
    send(32'h0100_0001, 2'd1, 1'b0, lat);
    check_eq("rtz_a", res_a, 32'h4B80_0000);
    send(32'hFEFF_FFFF, 2'd3, 1'b0, lat);
    check_eq("rdn_neg_a", res_a, 32'hCB80_0001);
    check_eq("rdn_neg_flags", flags_a, 2'b01);
    // Fixed-point fraction
    send(32'h0000_0180, 2'd0, 1'b0, lat);
    check_eq("frac_b", res_b, 32'h3FC0_0000);
    check_eq("frac_b_flags", flags_b, 2'b00);
    // Half-precision overflow under each mode
    send(32'd70000, 2'd0, 1'b0, lat);
    check_eq("ovf_rne_d", res_d, 16'h7C00);
    check_eq("ovf_rne_flags", flags_d, 2'b11);
    send(32'd70000, 2'd1, 1'b0, lat);
    check_eq("ovf_rtz_d", res_d, 16'h7BFF);
    check_eq("ovf_rtz_flags", flags_d, 2'b11);
    send(32'hFFFE_EE90, 2'd2, 1'b0, lat);
    check_eq("ovf_rup_neg_d", res_d, 16'hFBFF);
    send(32'hFFFE_EE90, 2'd3, 1'b0, lat);
    check_eq("ovf_rdn_neg_d", res_d, 16'hFC00);
    send(32'd65504, 2'd0, 1'b0, lat);
    check_eq("maxfin_d", res_d, 16'h7BFF);
    check_eq("maxfin_flags", flags_d, 2'b00);
    send(32'd65520, 2'd0, 1'b0, lat);
    check_eq("rnd_ovf_d", res_d, 16'h7C00);
    check_eq("rnd_ovf_flags", flags_d, 2'b11);

    // Randomised backpressure and clock-enable stream on A
    sent = 0; got = 0; cyc = 0; acc = 1'b0; prev_stall = 1'b0; prev_obs = '0;
    while (got < 20 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (acc) tvalid = 1'b0;
      if (!tvalid && sent < 20 && $urandom_range(0, 3) != 0) begin
        tdata  = $urandom;
        rnd    = 2'($urandom_range(0, 3));
        tuser  = 1'($urandom_range(0, 1));
        tvalid = 1'b1;
      end
      rdy = ($urandom_range(0, 2) != 0);
      en  = ($urandom_range(0, 4) != 0);
      #1;
      obs = {user_a, flags_a, res_a};
      if (prev_stall) check_eq("stall_hold", obs, prev_obs);
      acc = tvalid && a_rdy_a;
      if (acc) begin
        exp_d = ref_a(tdata, rnd, ix);
        exp_q.push_back({tuser, 1'b0, ix, exp_d});
        sent++;
      end
      if (ov_a && rdy && en) begin
        if (exp_q.size() == 0) check_eq("stream_extra", exp_q.size(), 1);
        else check_eq("stream", obs, exp_q.pop_front());
        got++;
      end
      prev_stall = ov_a && !(rdy && en);
      prev_obs   = obs;
    end
    check_eq("stream_count", got, 20);
    check_eq("stream_left", exp_q.size(), 0);

    // Reset with operands in flight
    @(negedge clk);
    en = 1'b1; rdy = 1'b1; tvalid = 1'b1;
    repeat (3) begin
      tdata = $urandom;
      @(negedge clk);
    end
    tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check_eq("midrst_async", ov_a, 0);
    @(posedge clk); #1;
    check_eq("midrst_tvalid", ov_a, 0);
    check_eq("midrst_tdata", res_a, 0);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov_a) cnt++;
    end
    check_eq("midrst_no_output", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
